// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   XLEN          : instruction / address width
//   INST_NOP      : instruction presented to if_id when nothing valid is buffered
//   ZERO_WORD     : address presented to if_id when nothing valid is buffered
//   fetch_entry_t : one buffered {instruction, address} pair
//   word_align    : clears the byte-offset bits of an address
package if_prefetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INST_NOP  = 32'h0000_0013;
  localparam logic [XLEN-1:0] ZERO_WORD = 32'h0000_0000;

  // One prefetch buffer slot: the fetched word and the PC it came from.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] addr;
  } fetch_entry_t;

  // Instruction fetches are always word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Small synchronous prefetch FIFO with flush and a combinational head.
//   clk, rst   : clock, synchronous active-low reset
//   flush      : empties the FIFO this cycle (wins over push/pop)
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : retire the head entry
//   count      : number of valid entries (registered)
//   head_c     : current head entry (combinational view of storage)
module if_fifo
  import if_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push_c;
  logic             do_pop_c;

  // Qualify requests so the storage can never underflow or overflow.
  always_comb begin
    do_pop_c  = 1'b0;
    do_push_c = 1'b0;
    if (!flush) begin
      do_pop_c  = pop & (count != '0);
      do_push_c = push & ((count != CNT_W'(DEPTH)) | do_pop_c);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push_c) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (do_pop_c) begin
        rptr <= rptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end
  end

  // Storage needs no reset; count qualifies every read.
  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem[wptr] <= push_data;
    end
  end

  assign head_c = mem[rptr];

endmodule

// File: rtl/if_prefetch.sv
// Instruction fetch front end: PC generation, single-outstanding instruction
// bus requests, a small prefetch FIFO and the {instruction, address} feed to
// if_id. A jump from ex flushes the FIFO and drops any in-flight response.
//   clk, rst                 : clock, synchronous active-low reset
//   jump_flag_i, jump_addr_i : redirect request and target from ex
//   hold_flag_i              : downstream stall, head entry is kept
//   ibus_req_o, ibus_addr_o  : fetch request and word-aligned address
//   ibus_gnt_i               : request accepted this cycle
//   ibus_rvalid_i/rdata_i    : response strobe and instruction word
//   inst_o, inst_addr_o      : head instruction and its address to if_id
//   inst_valid_o             : inst_o/inst_addr_o carry a fetched instruction
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned CRD_W = CNT_W + 1;

  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  req_addr;
  logic             outstanding;
  logic             discard;

  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     head_c;
  fetch_entry_t     push_entry_c;
  logic             fifo_valid_c;
  logic             pop_c;
  logic             push_c;
  logic             resp_c;
  logic             grant_c;
  logic             credit_ok_c;
  logic [CRD_W-1:0] in_use_c;

  // Request, credit and response qualification.
  always_comb begin
    fifo_valid_c = (fifo_count != '0);
    pop_c        = fifo_valid_c & ~hold_flag_i & ~jump_flag_i;

    // Slots spoken for after this cycle: buffered + in flight - retiring.
    in_use_c    = CRD_W'(fifo_count) + CRD_W'(outstanding) - CRD_W'(pop_c);
    credit_ok_c = (in_use_c < CRD_W'(DEPTH));

    // A response landing this cycle frees the single outstanding slot.
    ibus_req_o = rst & ~jump_flag_i & (~outstanding | ibus_rvalid_i) & credit_ok_c;
    grant_c    = ibus_req_o & ibus_gnt_i;

    resp_c = ibus_rvalid_i & outstanding;
    push_c = resp_c & ~discard & ~jump_flag_i;

    push_entry_c.inst = ibus_rdata_i;
    push_entry_c.addr = req_addr;
  end

  // PC, in-flight tracking and stale-response discard.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else begin
      if (jump_flag_i) begin
        pc <= word_align(jump_addr_i);
      end else if (grant_c) begin
        pc <= pc + XLEN'(4);
      end

      if (grant_c) begin
        req_addr <= pc;
      end

      if (grant_c) begin
        outstanding <= 1'b1;
      end else if (resp_c) begin
        outstanding <= 1'b0;
      end

      // A response still in flight across a jump belongs to the old stream.
      if (jump_flag_i && outstanding && !ibus_rvalid_i) begin
        discard <= 1'b1;
      end else if (resp_c) begin
        discard <= 1'b0;
      end
    end
  end

  if_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (jump_flag_i),
    .push     (push_c),
    .push_data(push_entry_c),
    .pop      (pop_c),
    .count    (fifo_count),
    .head_c   (head_c)
  );

  assign ibus_addr_o  = pc;
  assign inst_valid_o = fifo_valid_c;
  assign inst_o       = fifo_valid_c ? head_c.inst : INST_NOP;
  assign inst_addr_o  = fifo_valid_c ? head_c.addr : ZERO_WORD;

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: a bus stub with configurable grant and
// response latency, and a stream-level reference (expected next fetch
// address, expected next consumed address, buffered-instruction count).
module tb_if_prefetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        hold_flag;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_gnt;
  logic        ibus_rvalid;
  logic [31:0] ibus_rdata;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_valid;

  if_prefetch #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_flag_i  (jump_flag),
    .jump_addr_i  (jump_addr),
    .hold_flag_i  (hold_flag),
    .ibus_req_o   (ibus_req),
    .ibus_addr_o  (ibus_addr),
    .ibus_gnt_i   (ibus_gnt),
    .ibus_rvalid_i(ibus_rvalid),
    .ibus_rdata_i (ibus_rdata),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr),
    .inst_valid_o (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Bus stub: at most one request tracked, tagged with the stream epoch.
  bit          pend       = 1'b0;
  logic [31:0] pend_addr  = '0;
  int          pend_epoch = 0;
  int          pend_rem   = 0;
  int          lat_extra  = 0;

  // Stream reference.
  int          epoch          = 0;
  int          occ            = 0;
  logic [31:0] exp_addr       = RESET_PC;
  logic [31:0] fetch_addr     = RESET_PC;
  int          since_rst      = 0;
  int          first_valid_cyc = -1;

  // Values sampled in the current cycle.
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_inst, s_iaddr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a >> 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the response, sample, check, then advance.
  task automatic tick();
    logic granted;
    int   live;
    ibus_rvalid = pend && (pend_rem == 0);
    ibus_rdata  = ibus_rvalid ? mem_word(pend_addr) : $urandom;
    #1;
    s_req   = ibus_req;
    s_addr  = ibus_addr;
    s_valid = inst_valid;
    s_inst  = inst;
    s_iaddr = inst_addr;
    granted = 1'b0;
    if (rst) begin
      since_rst++;
      check("valid_vs_model", {31'b0, s_valid}, {31'b0, occ != 0});
      if (!s_valid) begin
        check("empty_inst", s_inst, NOP);
        check("empty_addr", s_iaddr, 32'h0);
      end else if (first_valid_cyc < 0) begin
        first_valid_cyc = since_rst;
      end
      if (s_valid && !hold_flag && !jump_flag) begin
        check("pop_addr", s_iaddr, exp_addr);
        check("pop_inst", s_inst, mem_word(exp_addr));
        exp_addr = exp_addr + 32'd4;
        occ--;
      end
      if (jump_flag) check("req_in_jump", {31'b0, s_req}, 32'h0);
      if (s_req) check("fetch_addr", s_addr, fetch_addr);
      if (ibus_rvalid && pend_epoch == epoch && !jump_flag) occ++;
      if (jump_flag) begin
        occ        = 0;
        epoch++;
        exp_addr   = jump_addr & 32'hFFFF_FFFC;
        fetch_addr = jump_addr & 32'hFFFF_FFFC;
      end
      granted = s_req && ibus_gnt;
      if (granted) begin
        check("one_outstanding", {31'b0, pend && !ibus_rvalid}, 32'h0);
        fetch_addr = fetch_addr + 32'd4;
      end
      live = granted ? 1 : ((pend && !ibus_rvalid && pend_epoch == epoch) ? 1 : 0);
      check("credit_bound", {31'b0, (occ + live) <= DEPTH}, 32'h1);
    end else begin
      epoch++;
      occ             = 0;
      exp_addr        = RESET_PC;
      fetch_addr      = RESET_PC;
      since_rst       = 0;
      first_valid_cyc = -1;
    end
    @(posedge clk);
    if (ibus_rvalid) pend = 1'b0;
    else if (pend && pend_rem > 0) pend_rem--;
    if (granted) begin
      pend       = 1'b1;
      pend_addr  = s_addr;
      pend_epoch = epoch;
      pend_rem   = lat_extra;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b0;
    jump_flag = 1'b0;
    hold_flag = 1'b0;
    for (int i = 0; i < n; i++) tick();
    #1;
    check("rst_req", {31'b0, ibus_req}, 32'h0);
    check("rst_addr", ibus_addr, RESET_PC);
    check("rst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_inst", inst, NOP);
    check("rst_inst_addr", inst_addr, 32'h0);
    rst = 1'b1;
  endtask

  task automatic run_until_valid(output int k);
    k = 20;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_valid) begin
        k = i + 1;
        break;
      end
    end
  endtask

  int          k;
  logic [31:0] held;

  initial begin
    rst       = 1'b0;
    jump_flag = 1'b0;
    jump_addr = '0;
    hold_flag = 1'b0;
    ibus_gnt  = 1'b1;
    ibus_rvalid = 1'b0;
    ibus_rdata  = '0;
    @(negedge clk);

    // Reset and free run: first valid three cycles after release.
    do_reset(2);
    for (int i = 0; i < 20 && first_valid_cyc < 0; i++) tick();
    check("first_valid_cycle", first_valid_cyc, 32'd3);
    repeat (10) tick();

    // Hold: buffer fills, requests stop, head stays put.
    hold_flag = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 1) held = s_iaddr;
      else begin
        check("hold_req_low", {31'b0, s_req}, 32'h0);
        check("hold_head_stable", s_iaddr, held);
        check("hold_full", {31'b0, s_valid && occ == DEPTH}, 32'h1);
      end
    end
    hold_flag = 1'b0;
    repeat (10) tick();

    // Jump while a response is still in flight.
    lat_extra = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pend && pend_rem == 1) break;
    end
    check("inflight_setup", {31'b0, pend && pend_rem == 1}, 32'h1);
    lat_extra = 0;
    jump_flag = 1'b1;
    jump_addr = 32'h0000_0100;
    tick();
    jump_flag = 1'b0;
    run_until_valid(k);
    check("jump_inflight_latency", k, 32'd3);
    check("jump_inflight_head", s_iaddr, 32'h0000_0100);
    repeat (6) tick();

    // Jump in the same cycle as a response.
    for (int i = 0; i < 10; i++) begin
      if (pend && pend_rem == 0) break;
      tick();
    end
    check("rvalid_at_jump", {31'b0, pend && pend_rem == 0}, 32'h1);
    jump_flag = 1'b1;
    jump_addr = 32'h0000_0203;
    tick();
    jump_flag = 1'b0;
    run_until_valid(k);
    check("jump_rvalid_latency", k, 32'd3);
    check("jump_rvalid_head", s_iaddr, 32'h0000_0200);
    repeat (6) tick();

    // Grant withheld, then slow response.
    do_reset(1);
    ibus_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nogrant_req", {31'b0, s_req}, 32'h1);
      check("nogrant_addr", s_addr, RESET_PC);
    end
    ibus_gnt  = 1'b1;
    lat_extra = 4;
    tick();
    lat_extra = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("slow_resp_req", {31'b0, s_req}, 32'h0);
      check("slow_resp_valid", {31'b0, s_valid}, 32'h0);
      check("slow_resp_inst", s_inst, NOP);
    end
    run_until_valid(k);
    check("slow_resp_head", s_iaddr, RESET_PC);
    repeat (5) tick();

    // Reset with a request outstanding; the late response is ignored.
    lat_extra = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pend && pend_rem == 1) break;
    end
    check("rst_inflight_setup", {31'b0, pend && pend_rem == 1}, 32'h1);
    lat_extra = 0;
    do_reset(1);
    run_until_valid(k);
    check("rst_restart_latency", first_valid_cyc, 32'd3);
    check("rst_restart_head", s_iaddr, RESET_PC);

    // Randomised traffic against the stream reference.
    for (int i = 0; i < 1500; i++) begin
      ibus_gnt  = ($urandom_range(9) < 7);
      lat_extra = $urandom_range(2);
      hold_flag = ($urandom_range(4) == 0);
      jump_flag = ($urandom_range(24) == 0);
      jump_addr = $urandom;
      tick();
    end
    jump_flag = 1'b0;
    hold_flag = 1'b0;
    ibus_gnt  = 1'b1;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
